// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART <-> ALU controller and the ALU itself:
//   default data/opcode widths, the 3-bit controller state encodings and the
//   ALU opcode values.
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   // Default widths
   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   // Controller state encodings
   localparam logic [2:0] ST_WAIT_A  = 3'd0;
   localparam logic [2:0] ST_WAIT_B  = 3'd1;
   localparam logic [2:0] ST_WAIT_OP = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   typedef enum logic [2:0] {
      WAIT_A  = ST_WAIT_A,
      WAIT_B  = ST_WAIT_B,
      WAIT_OP = ST_WAIT_OP,
      EXEC    = ST_EXEC,
      SEND    = ST_SEND,
      WAIT_TX = ST_WAIT_TX
   } state_t;

   // Opcodes understood by the ALU
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_intf.sv
// -----------------------------------------------------------------------------
// uart_alu_intf
//   Controller between the UART receiver/transmitter and the ALU. Collects
//   three received bytes (operand A, operand B, opcode), presents them to the
//   ALU, captures the ALU result and launches one UART transmission of it.
//
//   Optional feature: define UART_INTF_TIMEOUT_EN to abort a partial frame
//   after TIMEOUT_CYCLES idle cycles in WAIT_B/WAIT_OP. Without it the
//   controller waits forever and o_timeout is tied low.
//
// Ports
//   i_clk         clock
//   i_reset       synchronous, active-high reset
//   i_rx_done     one-cycle pulse, byte valid on i_rx_data
//   i_rx_data     received byte
//   i_tx_done     one-cycle pulse, TX finished the current byte
//   i_alu_result  combinational ALU result
//   o_alu_data_a  registered operand A
//   o_alu_data_b  registered operand B
//   o_alu_op      registered opcode (low NB_OP bits of the opcode byte)
//   o_tx_start    one-cycle pulse, start transmission of o_tx_data
//   o_tx_data     registered result byte
//   o_busy        high in EXEC, SEND and WAIT_TX
//   o_overrun     one-cycle pulse, a byte arrived while busy and was dropped
//   o_timeout     one-cycle pulse, a partial frame was aborted
// -----------------------------------------------------------------------------
module uart_alu_intf
   import uart_pkg::*;
#(
   parameter int NB_DATA        = NB_DATA_DEF,
   parameter int NB_OP          = NB_OP_DEF,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_data_a,
   output logic [NB_DATA-1:0] o_alu_data_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_overrun,
   output logic               o_timeout
);

   state_t             state_reg,    state_next;
   logic [NB_DATA-1:0] data_a_reg,   data_a_next;
   logic [NB_DATA-1:0] data_b_reg,   data_b_next;
   logic [NB_OP-1:0]   op_reg,       op_next;
   logic [NB_DATA-1:0] tx_data_reg,  tx_data_next;
   logic               tx_start_reg, tx_start_next;
   logic               overrun_reg,  overrun_next;
   logic               timeout_reg,  timeout_next;

`ifdef UART_INTF_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             cnt_expired;

   assign cnt_expired = (cnt_reg == CNT_LAST);
`endif

   // Next-state and output logic
   always_comb begin
      state_next    = state_reg;
      data_a_next   = data_a_reg;
      data_b_next   = data_b_reg;
      op_next       = op_reg;
      tx_data_next  = tx_data_reg;
      tx_start_next = 1'b0;
      overrun_next  = 1'b0;
      timeout_next  = 1'b0;
`ifdef UART_INTF_TIMEOUT_EN
      cnt_next      = '0;
`endif

      case (state_reg)
         WAIT_A: begin
            if (i_rx_done) begin
               data_a_next = i_rx_data;
               state_next  = WAIT_B;
            end
         end

         WAIT_B: begin
            if (i_rx_done) begin
               data_b_next = i_rx_data;
               state_next  = WAIT_OP;
            end
`ifdef UART_INTF_TIMEOUT_EN
            // An arriving byte wins over an expiring counter.
            else if (cnt_expired) begin
               state_next   = WAIT_A;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end

         WAIT_OP: begin
            if (i_rx_done) begin
               op_next    = i_rx_data[NB_OP-1:0];
               state_next = EXEC;
            end
`ifdef UART_INTF_TIMEOUT_EN
            else if (cnt_expired) begin
               state_next   = WAIT_A;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end

         EXEC: begin
            // Operands were registered last cycle, so the ALU output is
            // settled now. The start pulse is registered and lands in SEND.
            tx_data_next  = i_alu_result;
            tx_start_next = 1'b1;
            overrun_next  = i_rx_done;
            state_next    = SEND;
         end

         SEND: begin
            overrun_next = i_rx_done;
            state_next   = WAIT_TX;
         end

         WAIT_TX: begin
            overrun_next = i_rx_done;
            if (i_tx_done) begin
               state_next = WAIT_A;
            end
         end

         default: begin
            state_next = WAIT_A;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg    <= WAIT_A;
         data_a_reg   <= '0;
         data_b_reg   <= '0;
         op_reg       <= '0;
         tx_data_reg  <= '0;
         tx_start_reg <= 1'b0;
         overrun_reg  <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         data_a_reg   <= data_a_next;
         data_b_reg   <= data_b_next;
         op_reg       <= op_next;
         tx_data_reg  <= tx_data_next;
         tx_start_reg <= tx_start_next;
         overrun_reg  <= overrun_next;
         timeout_reg  <= timeout_next;
      end
   end

`ifdef UART_INTF_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
`endif

   assign o_alu_data_a = data_a_reg;
   assign o_alu_data_b = data_b_reg;
   assign o_alu_op     = op_reg;
   assign o_tx_data    = tx_data_reg;
   assign o_tx_start   = tx_start_reg;
   assign o_overrun    = overrun_reg;
`ifdef UART_INTF_TIMEOUT_EN
   assign o_timeout    = timeout_reg;
`else
   assign o_timeout    = 1'b0;
`endif
   assign o_busy       = (state_reg == EXEC) || (state_reg == SEND) ||
                         (state_reg == WAIT_TX);

endmodule
